rr_prio_arbiter: RTL and testbench

- Parametrised, registered N-channel request arbiter.
- Successor to the team's combinational casez priority decoders.
- Adds a runtime-selectable fixed-priority or round-robin mode, grant locking, and a hold-time limit.
- Sits in front of shared resources (bus masters, shared memory ports) and drives one-hot and encoded grant to the datapath mux.

---
 rtl/rr_prio_arbiter_pkg.sv | 14 +
 rtl/rr_prio_arbiter_if.sv | 27 ++
 rtl/rr_prio_arbiter_find_first.sv | 34 +++
 rtl/rr_prio_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_prio_arbiter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/rr_prio_arbiter_pkg.sv
// Shared constants for the round-robin / fixed-priority arbiter.
package rr_prio_arbiter_pkg;

    // Arbiter FSM: IDLE holds no grant, BUSY holds exactly one grant.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Values of the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_prio_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_prio_arbiter_if #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) ();
    logic [N-1:0]    req;
    logic            mode;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;

    modport master (
        output req,
        output mode,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  req,
        input  mode,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/rr_prio_arbiter_find_first.sv
// Circular first-set-bit search: first request at or above start_i, wrapping to 0.
module rr_find_first #(
    parameter  int N    = 4,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] start_i,
    output logic            found_o,
    output logic [IDXW-1:0] idx_o
);

    int              pos;
    logic [IDXW-1:0] pos_idx;

    // Scan from farthest to nearest so the nearest set bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDXW'(pos);
            if (req_i[pos_idx]) begin
                found_o = 1'b1;
                idx_o   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/rr_prio_arbiter.sv
// Registered N-channel arbiter: fixed priority or round-robin, grant lock and hold limit.
module rr_prio_arbiter
    import rr_prio_arbiter_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int HOLD_MAX = 8,
    localparam int IDXW     = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    rr_prio_arbiter_if.slave    arb
);

    // Counter only needs to reach HOLD_MAX-1.
    localparam int              CNTW      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N - 1);

    arb_state_e      state_q,    state_d;
    logic [N-1:0]    gnt_q,      gnt_d;
    logic [IDXW-1:0] gnt_idx_q,  gnt_idx_d;
    logic            gnt_vld_q,  gnt_vld_d;
    logic [IDXW-1:0] last_idx_q, last_idx_d;
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;

    logic [IDXW-1:0] rr_start;
    logic [IDXW-1:0] search_start;
    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic            cur_req;
    logic            others_req;
    logic            timeout_hit;

    // Round-robin search begins just past the last winner; fixed priority always from 0.
    // While BUSY, last_idx equals the held index, so a timeout search starts at g+1.
    assign rr_start     = (last_idx_q == IDX_LAST) ? '0 : last_idx_q + IDXW'(1);
    assign search_start = (arb.mode == MODE_RR) ? rr_start : '0;

    rr_find_first #(.N(N)) u_find_first (
        .req_i   (arb.req),
        .start_i (search_start),
        .found_o (win_found),
        .idx_o   (win_idx)
    );

    assign cur_req     = arb.req[gnt_idx_q];
    assign others_req  = |(arb.req & ~gnt_q);
    assign timeout_hit = (arb.mode == MODE_RR) && (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);

    // Next-state decode for the FSM, grant, pointer and hold counter.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = BUSY;
                    gnt_d      = N'(1) << win_idx;
                    gnt_idx_d  = win_idx;
                    last_idx_d = win_idx;
                    hold_cnt_d = '0;
                end
            end
            BUSY: begin
                if (!cur_req) begin
                    // Release: hand over on this same edge, or drop to IDLE.
                    hold_cnt_d = '0;
                    if (win_found) begin
                        gnt_d      = N'(1) << win_idx;
                        gnt_idx_d  = win_idx;
                        last_idx_d = win_idx;
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                    end
                end else if (timeout_hit) begin
                    // Holder still requesting at its limit: rotate away if anyone waits.
                    hold_cnt_d = '0;
                    if (others_req) begin
                        gnt_d      = N'(1) << win_idx;
                        gnt_idx_d  = win_idx;
                        last_idx_d = win_idx;
                    end
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_idx_d = '0;
            end
        endcase

        gnt_vld_d = |gnt_d;
    end

    // State and output registers; reset clears outputs without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            last_idx_q <= IDX_LAST;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            last_idx_q <= last_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_idx   = gnt_idx_q;
    assign arb.gnt_valid = gnt_vld_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Scoreboard bench for rr_prio_arbiter with N=4, HOLD_MAX=8.
module tb_rr_prio_arbiter;

    localparam int N        = 4;
    localparam int HOLD_MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_prio_arbiter_if #(.N(N)) arb_if ();

    rr_prio_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       phase   = "init";
    logic [3:0]  sb_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Drive one cycle of stimulus and record the grant expected after the next edge.
    task automatic step(input logic [3:0] r, input logic m, input logic [3:0] exp_gnt);
        @(negedge clk);
        arb_if.req  = r;
        arb_if.mode = m;
        sb_q.push_back(exp_gnt);
    endtask

    task automatic step_n(input int n, input logic [3:0] r, input logic m, input logic [3:0] exp_gnt);
        for (int i = 0; i < n; i++) step(r, m, exp_gnt);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        arb_if.req  = '0;
        arb_if.mode = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_gnt",   arb_if.gnt,       0);
        chk("rst_idx",   arb_if.gnt_idx,   0);
        chk("rst_valid", arb_if.gnt_valid, 0);
    endtask

    // Monitor: invariant every cycle, scoreboard compare when an expectation is pending.
    always @(posedge clk) begin
        logic [3:0] exp_g;
        #1;
        if (!rst) begin
            chk("onehot0",   32'($onehot0(arb_if.gnt)), 1);
            chk("idx_match", arb_if.gnt_idx, idx_of(arb_if.gnt));
            chk("vld_match", arb_if.gnt_valid, |arb_if.gnt);
            if (sb_q.size() > 0) begin
                exp_g = sb_q.pop_front();
                chk("gnt",       arb_if.gnt,       exp_g);
                chk("gnt_idx",   arb_if.gnt_idx,   idx_of(exp_g));
                chk("gnt_valid", arb_if.gnt_valid, |exp_g);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        arb_if.req  = '0;
        arb_if.mode = 1'b0;

        // Async reset while a grant is held, then idle.
        phase = "reset";
        reset_dut();
        step_n(2, 4'b0100, 1'b0, 4'b0100);
        @(posedge clk);
        #3;
        chk("pre_gnt", arb_if.gnt, 4'b0100);
        rst = 1'b1;
        #1;
        chk("async_gnt",   arb_if.gnt,       0);
        chk("async_idx",   arb_if.gnt_idx,   0);
        chk("async_valid", arb_if.gnt_valid, 0);
        arb_if.req = '0;
        @(negedge clk);
        rst = 1'b0;
        step_n(5, 4'b0000, 1'b0, 4'b0000);

        // Fixed priority: lowest index wins, no timeout, next in line on release.
        phase = "fixed";
        reset_dut();
        step(4'b1010, 1'b0, 4'b0010);
        step_n(20, 4'b1010, 1'b0, 4'b0010);
        step(4'b1000, 1'b0, 4'b1000);
        step(4'b0000, 1'b0, 4'b0000);

        // Round-robin rotation with back-to-back handover.
        phase = "rr_rot";
        reset_dut();
        step(4'b1111, 1'b1, 4'b0001);
        step(4'b1110, 1'b1, 4'b0010);
        step(4'b1101, 1'b1, 4'b0100);
        step(4'b1011, 1'b1, 4'b1000);
        step(4'b0111, 1'b1, 4'b0001);

        // Hold limit: each holder keeps the grant exactly HOLD_MAX cycles.
        phase = "timeout";
        reset_dut();
        step_n(HOLD_MAX, 4'b0011, 1'b1, 4'b0001);
        step_n(HOLD_MAX, 4'b0011, 1'b1, 4'b0010);
        step_n(2,        4'b0011, 1'b1, 4'b0001);

        // Sole requester is never dropped at the limit.
        phase = "sole";
        reset_dut();
        step_n(30, 4'b0100, 1'b1, 4'b0100);

        // Mode switch while a grant is held: no pre-emption, no timeout in fixed mode.
        phase = "mode_sw";
        reset_dut();
        step(4'b1000, 1'b1, 4'b1000);
        step_n(12, 4'b1001, 1'b0, 4'b1000);
        step(4'b0001, 1'b0, 4'b0001);
        step(4'b0000, 1'b0, 4'b0000);

        phase = "end";
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
